cache_ctrl_assoc: RTL and testbench

//  Parametrised N-way set-associative write-back cache controller FSM; next generation of the direct-mapped controller.

---
 rtl/cache_ctrl_pkg.sv | 40 ++++
 rtl/mem_return_pipe.sv | 36 +++
 rtl/cache_ctrl_assoc.sv | 202 ++++++++++++++++++++
 tb/tb_cache_ctrl_assoc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - state encoding and helper functions for the set-associative cache controller
package cache_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WB    = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WB    = ST_WB,
        S_FILL  = ST_FILL,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int off_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic logic [31:0] onehot32(input int idx);
        return 32'd1 << idx;
    endfunction

    // Lowest index i < n with v[i] == 0, or -1 when none.
    function automatic int first_zero(input logic [31:0] v, input int n);
        int r;
        r = -1;
        for (int i = 31; i >= 0; i--) begin
            if (i < n && !v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_return_pipe.sv
// rtl/mem_return_pipe.sv - fixed-depth shift register tracking in-flight memory read returns
module mem_return_pipe #(
    parameter int DEPTH = 2,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [OFF_W-1:0] in_off,
    output logic             head_vld,
    output logic [OFF_W-1:0] head_off
);

    logic [DEPTH-1:0] vld;
    logic [OFF_W-1:0] off [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            vld <= '0;
        end else begin
            vld[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
        end
    end

    // Offsets only matter while their valid bit is set, so they need no clear.
    always_ff @(posedge clk) begin
        off[0] <= in_off;
        for (int i = 1; i < DEPTH; i++) off[i] <= off[i-1];
    end

    assign head_vld = vld[DEPTH-1];
    assign head_off = off[DEPTH-1];

endmodule

// File: rtl/cache_ctrl_assoc.sv
// rtl/cache_ctrl_assoc.sv - N-way set-associative write-back cache controller with pipelined line fill
// Optional CACHE_CTRL_STATS_EN adds saturating hit/miss/write-back counter ports.
module cache_ctrl_assoc
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    localparam int WAY_W  = way_w(WAYS),
    localparam int OFF_W  = off_w(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd,
    input  logic             wr,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  dirty,
    input  logic             mem_stall,
    output logic             stall,
    output logic             done,
    output logic             cache_hit,
    output logic             err,
    output logic             comp,
    output logic             cache_wr,
    output logic             valid_in,
    output logic [WAYS-1:0]  way_sel,
    output logic [OFF_W-1:0] cache_off,
    output logic             cache_src,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [OFF_W-1:0] mem_off,
    output logic             mem_tag_sel
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt,
    output logic [31:0]      wb_cnt_tot
`endif
);

    state_t           state, state_nx;
    logic [WAY_W-1:0] victim, vic_comb, rr_ptr;
    logic [OFF_W-1:0] wb_cnt, iss_cnt;
    logic [OFF_W:0]   ret_cnt;
    logic [WAYS-1:0]  hv, victim_oh;
    logic             req, both, one_hit, multi_hit, vic_dirty;
    logic             head_vld, pipe_in_vld;
    logic [OFF_W-1:0] head_off;
    logic             wb_last, iss_last, ret_last, ret_now;
    int               fz;

    assign hv        = hit & valid;
    assign req       = rd | wr;
    assign both      = rd & wr;
    assign one_hit   = $onehot(hv);
    assign multi_hit = (hv != '0) && !one_hit;
    assign victim_oh = WAYS'(onehot32(int'(victim)));
    assign wb_last   = (wb_cnt == OFF_W'(WORDS - 1));
    assign iss_last  = (iss_cnt == OFF_W'(WORDS - 1));
    assign ret_last  = (ret_cnt == (OFF_W + 1)'(WORDS - 1));
    assign ret_now   = head_vld && (state == S_FILL || state == S_DRAIN);
    assign pipe_in_vld = (state == S_FILL) && !mem_stall;

    // Prefer an empty way; only evict round-robin when the set is full.
    always_comb begin
        fz        = first_zero(32'(valid), WAYS);
        vic_comb  = (fz < 0) ? rr_ptr : WAY_W'(fz);
        vic_dirty = dirty[vic_comb] & valid[vic_comb];
    end

    mem_return_pipe #(
        .DEPTH (MEM_LAT),
        .OFF_W (OFF_W)
    ) u_ret_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_IDLE),
        .in_vld   (pipe_in_vld),
        .in_off   (iss_cnt),
        .head_vld (head_vld),
        .head_off (head_off)
    );

    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        done        = 1'b0;
        cache_hit   = 1'b0;
        err         = 1'b0;
        comp        = 1'b0;
        cache_wr    = 1'b0;
        valid_in    = 1'b0;
        way_sel     = '0;
        cache_off   = '0;
        cache_src   = 1'b0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_off     = '0;
        mem_tag_sel = 1'b0;
        case (state)
            S_IDLE: begin
                if (both) begin
                    err = 1'b1;
                end else if (req) begin
                    comp    = 1'b1;
                    way_sel = hv;
                    if (one_hit) begin
                        cache_hit = 1'b1;
                        done      = 1'b1;
                        cache_wr  = wr;
                    end else begin
                        stall    = 1'b1;
                        err      = multi_hit;
                        state_nx = vic_dirty ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                stall       = 1'b1;
                mem_wr      = 1'b1;
                mem_tag_sel = 1'b1;
                way_sel     = victim_oh;
                mem_off     = wb_cnt;
                cache_off   = wb_cnt;
                if (!mem_stall && wb_last) state_nx = S_FILL;
            end
            S_FILL: begin
                stall   = 1'b1;
                mem_rd  = 1'b1;
                mem_off = iss_cnt;
                if (!mem_stall && iss_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (head_vld && ret_last) state_nx = S_DONE;
            end
            S_DONE: begin
                stall    = 1'b1;
                comp     = 1'b1;
                way_sel  = victim_oh;
                cache_wr = wr;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Returning fill words land in the victim line regardless of issue progress.
        if (ret_now) begin
            cache_wr  = 1'b1;
            cache_src = 1'b1;
            valid_in  = 1'b1;
            cache_off = head_off;
            way_sel   = victim_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            victim  <= '0;
            rr_ptr  <= '0;
            wb_cnt  <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && state_nx != S_IDLE) victim <= vic_comb;
            if (state == S_DONE)
                rr_ptr <= (32'(rr_ptr) == WAYS - 1) ? '0 : rr_ptr + 1'b1;

            if (state_nx == S_WB && state != S_WB) wb_cnt <= '0;
            else if (state == S_WB && !mem_stall) wb_cnt <= wb_cnt + 1'b1;

            if (state_nx == S_FILL && state != S_FILL) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
            end else begin
                if (pipe_in_vld) iss_cnt <= iss_cnt + 1'b1;
                if (ret_now) ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            wb_cnt_tot <= '0;
        end else begin
            if (state == S_IDLE && req && !both && one_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (state == S_DONE && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
            if (state == S_WB && state_nx == S_FILL && wb_cnt_tot != '1)
                wb_cnt_tot <= wb_cnt_tot + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb/tb_cache_ctrl_assoc.sv - self-checking bench for cache_ctrl_assoc against a transaction timeline model
module tb_cache_ctrl_assoc;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int OFF_W   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rd = 1'b0, wr = 1'b0, mem_stall = 1'b0;
    logic [WAYS-1:0]  hit = '0, valid = '0, dirty = '0;
    logic             stall, done, cache_hit, err, comp, cache_wr, valid_in;
    logic [WAYS-1:0]  way_sel;
    logic [OFF_W-1:0] cache_off, mem_off;
    logic             cache_src, mem_wr, mem_rd, mem_tag_sel;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0]      hit_cnt, miss_cnt, wb_cnt_tot;
`endif

    always #5 clk = ~clk;

    cache_ctrl_assoc #(
        .WAYS    (WAYS),
        .WORDS   (WORDS),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd          (rd),
        .wr          (wr),
        .hit         (hit),
        .valid       (valid),
        .dirty       (dirty),
        .mem_stall   (mem_stall),
        .stall       (stall),
        .done        (done),
        .cache_hit   (cache_hit),
        .err         (err),
        .comp        (comp),
        .cache_wr    (cache_wr),
        .valid_in    (valid_in),
        .way_sel     (way_sel),
        .cache_off   (cache_off),
        .cache_src   (cache_src),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_off     (mem_off),
        .mem_tag_sel (mem_tag_sel)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
        .wb_cnt_tot  (wb_cnt_tot)
`endif
    );

    typedef struct {
        bit stall, done, cache_hit, err, comp, cache_wr, valid_in, cache_src;
        bit mem_wr, mem_rd, mem_tag_sel, care_way, care_off;
        bit [WAYS-1:0]  way_sel;
        bit [OFF_W-1:0] cache_off, mem_off;
    } exp_t;

    exp_t            ex [64];
    exp_t            cur;
    bit              chk_en = 1'b0;
    int              cyc = -1;
    int              total = 0, bad = 0;
    int              m_rr = 0;
    int              obs_done = -1, obs_ret = 0;
    logic [WAYS-1:0] obs_way = '0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",       cyc, 32'(stall),       32'(cur.stall));
            chk("done",        cyc, 32'(done),        32'(cur.done));
            chk("cache_hit",   cyc, 32'(cache_hit),   32'(cur.cache_hit));
            chk("err",         cyc, 32'(err),         32'(cur.err));
            chk("comp",        cyc, 32'(comp),        32'(cur.comp));
            chk("cache_wr",    cyc, 32'(cache_wr),    32'(cur.cache_wr));
            chk("valid_in",    cyc, 32'(valid_in),    32'(cur.valid_in));
            chk("cache_src",   cyc, 32'(cache_src),   32'(cur.cache_src));
            chk("mem_wr",      cyc, 32'(mem_wr),      32'(cur.mem_wr));
            chk("mem_rd",      cyc, 32'(mem_rd),      32'(cur.mem_rd));
            chk("mem_tag_sel", cyc, 32'(mem_tag_sel), 32'(cur.mem_tag_sel));
            if (cur.care_way) chk("way_sel", cyc, 32'(way_sel), 32'(cur.way_sel));
            if (cur.care_off) chk("cache_off", cyc, 32'(cache_off), 32'(cur.cache_off));
            if (cur.mem_rd || cur.mem_wr) chk("mem_off", cyc, 32'(mem_off), 32'(cur.mem_off));
            if (done === 1'b1) begin
                obs_done = cyc;
                obs_way  = way_sel;
            end
            if (cache_wr === 1'b1 && cache_src === 1'b1) obs_ret++;
        end
    end

    // Timeline model: phases of accepted memory transfers, returns MEM_LAT after issue.
    task automatic build(input bit r, input bit w, input logic [WAYS-1:0] h, input logic [WAYS-1:0] v,
                         input logic [WAYS-1:0] d, input logic [31:0] sm, output int n, output bit miss);
        logic [WAYS-1:0] hv;
        int vic, t, k, last;
        for (int i = 0; i < 64; i++) ex[i] = '{default: 0};
        hv   = h & v;
        miss = 1'b0;
        n    = 1;
        if (r && w) begin
            ex[0].err      = 1'b1;
            ex[0].care_way = 1'b1;
        end else if ($countones(hv) == 1) begin
            ex[0].comp      = 1'b1;
            ex[0].done      = 1'b1;
            ex[0].cache_hit = 1'b1;
            ex[0].cache_wr  = w;
            ex[0].way_sel   = hv;
            ex[0].care_way  = 1'b1;
        end else begin
            miss = 1'b1;
            ex[0].comp     = 1'b1;
            ex[0].err      = ($countones(hv) > 1);
            ex[0].way_sel  = hv;
            ex[0].care_way = 1'b1;
            vic = -1;
            for (int i = WAYS - 1; i >= 0; i--) if (!v[i]) vic = i;
            if (vic < 0) vic = m_rr;
            t = 1;
            if (d[vic] && v[vic]) begin
                k = 0;
                while (k < WORDS) begin
                    ex[t].mem_wr      = 1'b1;
                    ex[t].mem_tag_sel = 1'b1;
                    ex[t].way_sel     = WAYS'(1 << vic);
                    ex[t].care_way    = 1'b1;
                    ex[t].mem_off     = OFF_W'(k);
                    ex[t].cache_off   = OFF_W'(k);
                    ex[t].care_off    = 1'b1;
                    if (!sm[t]) k++;
                    t++;
                end
            end
            k = 0;
            last = 0;
            while (k < WORDS) begin
                ex[t].mem_rd  = 1'b1;
                ex[t].mem_off = OFF_W'(k);
                if (!sm[t]) begin
                    last = t + MEM_LAT;
                    ex[last].cache_wr  = 1'b1;
                    ex[last].cache_src = 1'b1;
                    ex[last].valid_in  = 1'b1;
                    ex[last].cache_off = OFF_W'(k);
                    ex[last].care_off  = 1'b1;
                    ex[last].way_sel   = WAYS'(1 << vic);
                    ex[last].care_way  = 1'b1;
                    k++;
                end
                t++;
            end
            ex[last+1].comp     = 1'b1;
            ex[last+1].done     = 1'b1;
            ex[last+1].cache_wr = w;
            ex[last+1].way_sel  = WAYS'(1 << vic);
            ex[last+1].care_way = 1'b1;
            for (int i = 0; i <= last + 1; i++) ex[i].stall = 1'b1;
            n = last + 2;
        end
    endtask

    task automatic idle_cycle(input bit rv);
        @(posedge clk);
        #1;
        rst = rv; rd = 1'b0; wr = 1'b0; hit = '0; valid = '0; dirty = '0; mem_stall = 1'b0;
        cur = '{default: 0};
        cur.care_way = 1'b1;
        cyc = -1;
    endtask

    task automatic run(input string nm, input bit r, input bit w, input logic [WAYS-1:0] h,
                       input logic [WAYS-1:0] v, input logic [WAYS-1:0] d, input logic [31:0] sm,
                       input int abort_at, input int want_done, input logic [WAYS-1:0] want_way);
        int n;
        bit miss;
        build(r, w, h, v, d, sm, n, miss);
        obs_done = -1;
        obs_ret  = 0;
        obs_way  = '0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            rd = r; wr = w; hit = h; valid = v; dirty = d; mem_stall = sm[t];
            cur = ex[t];
            cyc = t;
            if (t == abort_at) begin
                rst = 1'b0;
                break;
            end
        end
        if (abort_at >= 0) m_rr = 0;
        else if (miss) m_rr = (m_rr + 1) % WAYS;
        idle_cycle(1'b1);
        chk({nm, "_done_cycle"}, -1, 32'(obs_done), 32'(want_done));
        if (want_done >= 0) chk({nm, "_done_way"}, -1, 32'(obs_way), 32'(want_way));
        if (miss && abort_at < 0) chk({nm, "_returns"}, -1, 32'(obs_ret), 32'(WORDS));
    endtask

    initial begin
        rst = 1'b0;
        idle_cycle(1'b0);
        chk_en = 1'b1;
        idle_cycle(1'b0);
`ifdef CACHE_CTRL_STATS_EN
        chk("reset_hit_cnt", -1, hit_cnt, 32'd0);
`endif
        idle_cycle(1'b1);

        run("rd_hit_way1",    1, 0, 2'b10, 2'b11, 2'b00, 32'h0,  -1,  0, 2'b10);
        run("rd_miss_clean",  1, 0, 2'b00, 2'b10, 2'b00, 32'h0,  -1,  7, 2'b01);
        run("wr_miss_dirty",  0, 1, 2'b00, 2'b11, 2'b11, 32'h0,  -1, 11, 2'b10);
        run("fill_stall",     1, 0, 2'b00, 2'b10, 2'b00, 32'h4,  -1,  8, 2'b01);
        run("wr_hit_way0",    0, 1, 2'b01, 2'b11, 2'b11, 32'h0,  -1,  0, 2'b01);
        run("rd_wr_err",      1, 1, 2'b00, 2'b11, 2'b00, 32'h0,  -1, -1, 2'b00);
        run("multi_hit",      1, 0, 2'b11, 2'b11, 2'b00, 32'h0,  -1,  7, 2'b10);
        run("lowest_invalid", 1, 0, 2'b00, 2'b01, 2'b00, 32'h0,  -1,  7, 2'b10);
        run("wb_stall",       0, 1, 2'b00, 2'b11, 2'b10, 32'h4,  -1, 12, 2'b10);
        run("reset_in_drain", 1, 0, 2'b00, 2'b10, 2'b00, 32'h0,   5, -1, 2'b00);
        run("full_set_a",     1, 0, 2'b00, 2'b11, 2'b00, 32'h0,  -1,  7, 2'b01);
        run("full_set_b",     1, 0, 2'b00, 2'b11, 2'b00, 32'h0,  -1,  7, 2'b10);
`ifdef CACHE_CTRL_STATS_EN
        chk("stats_miss_cnt", -1, miss_cnt,   32'd2);
        chk("stats_hit_cnt",  -1, hit_cnt,    32'd0);
        chk("stats_wb_cnt",   -1, wb_cnt_tot, 32'd0);
`endif
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
